multi_sensor_poll_arbiter: RTL and testbench
============================================

Name: multi_sensor_poll_arbiter

Overview:
Sits between the UART-to-I2C instruction path and the I2C controller. It generalises the single-sensor default 2-byte temperature read to NUM_SENSORS ADT7420 devices polled on a programmable period. It buffers PC instructions in a parametrised FIFO and arbitrates fairly between PC instructions and periodic polls. It issues one transaction at a time to the I2C controller, tagged with source and device index, for the downstream result stage.

Parameters:
NUM_SENSORS, 4, number of sensors (1..4); device i uses bus address BASE_ADDR+i
FIFO_DEPTH, 8, PC instruction FIFO depth (power of 2, >=2)
SYS_FREQ, 100000000, clock frequency in Hz
POLL_MS, 250, poll period in ms; POLL_CYCLES = SYS_FREQ/1000*POLL_MS
DATA_W, 16, instruction data width
BASE_ADDR, 7'b1001000, bus address of sensor 0
POLL_MODE, 8'h02, operation byte for a 2-byte read
POLL_REG, 8'h00, register pointer for a poll (temperature MSB)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pc_valid  in  1  PC instruction offered
pc_ready  out  1  FIFO accepts; = !fifo_full && !reset
pc_dev  in  DW=max(1,$clog2(NUM_SENSORS))  target sensor index
pc_mode  in  8  operation byte
pc_reg  in  8  register pointer
pc_data  in  DATA_W  write data
enable_mask  in  NUM_SENSORS  sensors included in poll rounds
i2c_free  in  1  controller idle
downstream_full  in  1  result buffers full; blocks new grants
i2c_start  out  1  one-cycle launch pulse
i2c_busaddr  out  7  BASE_ADDR + device index
i2c_mode  out  8  operation byte
i2c_reg  out  8  register pointer
i2c_data  out  DATA_W  write data (0 for polls)
i2c_src  out  1  1 = PC instruction, 0 = poll
i2c_dev  out  DW  device index
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
fifo_full  out  1  count == FIFO_DEPTH
poll_overrun  out  1  one-cycle pulse: period expired while previous round unfinished

Behaviour:
- Reset: FIFO emptied, count 0, FSM IDLE, poll timer 0, poll_pending 0, poll_idx 0, last_grant_pc 0. All i2c_* outputs, poll_overrun and fifo_full are 0. pc_ready is 0 during reset and 1 on the first cycle after. Reset mid-transaction abandons it with no further i2c_start.
- FIFO: push on pc_valid && pc_ready; an entry is visible to the arbiter the next cycle. Pop occurs on the grant cycle. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo FIFO_DEPTH. A push while full is impossible because pc_ready=0.
- Poll timer: counts 0..POLL_CYCLES-1 and wraps. On wrap it sets poll_pending and loads poll_idx with the lowest enabled index. If poll_pending is already set at wrap, poll_overrun pulses, the round continues unchanged and no second round is queued.
- Poll round: one enabled sensor per grant, in ascending index order. After granting the highest enabled index, poll_pending clears. If enable_mask is 0 at a wrap, or becomes 0 mid-round, poll_pending clears with no grant. Disabled indices are skipped.
- FSM IDLE: a grant is possible when i2c_free && !downstream_full && (FIFO non-empty || poll_pending).
  - Both sources ready: poll wins if last_grant_pc=1; otherwise PC wins. This gives strict alternation under contention.
  - One source ready: it wins.
  - On grant: register the output fields, pulse i2c_start for one cycle, update last_grant_pc, go to WAIT_ACCEPT.
  - Poll field values: busaddr=BASE_ADDR+idx, mode=POLL_MODE, reg=POLL_REG, data=0, src=0.
  - PC field values: the FIFO head fields, src=1.
- WAIT_ACCEPT: wait for i2c_free=0, then go to WAIT_DONE.
- WAIT_DONE: wait for i2c_free=1, then go to IDLE. The earliest next grant is one cycle later.
- i2c_* fields are held stable from the i2c_start cycle until IDLE is re-entered.
- Latency: a push at cycle T with FSM IDLE, i2c_free=1 and no poll contention gives i2c_start high at T+2.
- Out-of-range pc_dev (>= NUM_SENSORS) is passed through unchanged; addressing it is the sender's responsibility.

Test Plan:
- Use SYS_FREQ=10000, POLL_MS=1 (10-cycle period), NUM_SENSORS=4, enable_mask=4'b1011, PC idle, controller modelled free→busy 1 cycle after start→free after 3 cycles. Required: each round issues busaddr 0x48, 0x49, 0x4B with mode 0x02, reg 0x00, src 0, then poll_pending clears.
- Push one PC instruction (dev 2, mode 0x03, reg 0x03, data 0x1234) at cycle T into an idle system. Required: i2c_start at T+2 with busaddr 0x4A, src 1, data 0x1234.
- Fill the FIFO with 8 entries while i2c_free=0. Required: fifo_full=1, pc_ready=0, count=8. Releasing the controller drains the entries in push order.
- Keep the FIFO non-empty with poll_pending. Required: grants alternate PC, poll, PC, poll.
- Set a slow controller (busy for 25 cycles). Required: a poll_overrun pulse at the second wrap, and no duplicate round.
- Assert downstream_full with work pending. Required: no i2c_start until it deasserts. Reset during WAIT_DONE: outputs 0, count 0, FSM IDLE next cycle.

Source files
------------

// File: rtl/multi_sensor_poll_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : multi_sensor_poll_arbiter
// Purpose  : Buffers PC instructions in a FIFO and periodically polls up to
//            NUM_SENSORS ADT7420 devices. It arbitrates fairly between the two
//            sources and issues one tagged transaction at a time to the I2C
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
module multi_sensor_poll_arbiter #(
  parameter int         NUM_SENSORS = 4,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         SYS_FREQ    = 100000000,
  parameter int         POLL_MS     = 250,
  parameter int         DATA_W      = 16,
  parameter logic [6:0] BASE_ADDR   = 7'b1001000,
  parameter logic [7:0] POLL_MODE   = 8'h02,
  parameter logic [7:0] POLL_REG    = 8'h00,
  localparam int        DW          = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1,
  localparam int        CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [DW-1:0]     pc_dev,
  input  logic [7:0]        pc_mode,
  input  logic [7:0]        pc_reg,
  input  logic [DATA_W-1:0] pc_data,
  input  logic [NUM_SENSORS-1:0] enable_mask,
  input  logic              i2c_free,
  input  logic              downstream_full,
  output logic              i2c_start,
  output logic [6:0]        i2c_busaddr,
  output logic [7:0]        i2c_mode,
  output logic [7:0]        i2c_reg,
  output logic [DATA_W-1:0] i2c_data,
  output logic              i2c_src,
  output logic [DW-1:0]     i2c_dev,
  output logic [CW-1:0]     fifo_count,
  output logic              fifo_full,
  output logic              poll_overrun
);

  localparam int POLL_CYCLES = SYS_FREQ / 1000 * POLL_MS;
  localparam int TW          = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int EW          = DW + 8 + 8 + DATA_W;

  localparam logic [TW-1:0] TIMER_LAST    = TW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_WAIT_ACCEPT = 2'd1;
  localparam logic [1:0] S_WAIT_DONE   = 2'd2;

  // FIFO storage and bookkeeping
  logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push;
  logic              pop;
  logic [DW-1:0]     head_dev;
  logic [7:0]        head_mode;
  logic [7:0]        head_reg;
  logic [DATA_W-1:0] head_data;

  // Poll timer and round state
  logic [TW-1:0]     timer_q;
  logic              wrap;
  logic              poll_pending_q;
  logic [DW-1:0]     poll_idx_q;
  logic              poll_overrun_q;
  logic              poll_have;
  logic              poll_more;
  logic [DW-1:0]     poll_sel;
  logic [DW-1:0]     lowest_en;

  // Arbitration / FSM
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              pc_avail;
  logic              poll_avail;
  logic              grant;
  logic              pick_poll;
  logic              grant_poll;
  logic              last_grant_pc_q;

  // Registered transaction fields
  logic              start_q;
  logic [6:0]        busaddr_q;
  logic [7:0]        mode_q;
  logic [7:0]        reg_q;
  logic [DATA_W-1:0] data_q;
  logic              src_q;
  logic [DW-1:0]     dev_q;

  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign pc_ready   = !fifo_full && !reset;
  assign fifo_count = count_q;
  assign push       = pc_valid && pc_ready;
  assign pop        = grant && !pick_poll;
  assign {head_dev, head_mode, head_reg, head_data} = fifo_mem_q[rd_ptr_q];

  // Capture an accepted PC instruction into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {pc_dev, pc_mode, pc_reg, pc_data};
    end
  end

  // FIFO pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Free-running poll period counter
  assign wrap = (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= wrap ? '0 : timer_q + TW'(1);
    end
  end

  // Find the next enabled sensor at or above the round cursor, whether any
  // enabled sensor lies beyond it, and the lowest enabled sensor overall
  always_comb begin
    poll_have = 1'b0;
    poll_sel  = '0;
    poll_more = 1'b0;
    lowest_en = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (enable_mask[i]) begin
        lowest_en = DW'(i);
        if (i >= int'(poll_idx_q)) begin
          poll_have = 1'b1;
          poll_sel  = DW'(i);
        end
      end
    end
    for (int j = 0; j < NUM_SENSORS; j++) begin
      if (enable_mask[j] && (j > int'(poll_sel))) begin
        poll_more = 1'b1;
      end
    end
  end

  // Round bookkeeping: start a round on wrap, advance per poll grant, and
  // drop the round once no enabled sensor remains ahead of the cursor
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_pending_q <= 1'b0;
      poll_idx_q     <= '0;
      poll_overrun_q <= 1'b0;
    end else begin
      poll_overrun_q <= wrap && poll_pending_q;
      if (wrap && !poll_pending_q) begin
        if (|enable_mask) begin
          poll_pending_q <= 1'b1;
          poll_idx_q     <= lowest_en;
        end
      end else if (grant_poll) begin
        if (poll_more) begin
          poll_idx_q <= poll_sel + DW'(1);
        end else begin
          poll_pending_q <= 1'b0;
        end
      end else if (poll_pending_q && !poll_have) begin
        poll_pending_q <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: launch, wait for the controller to go busy, then idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (grant)     state_d = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: if (!i2c_free) state_d = S_WAIT_DONE;
      S_WAIT_DONE:   if (i2c_free)  state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // FSM outputs: grant decision with alternation under contention
  always_comb begin
    pc_avail   = (count_q != '0);
    poll_avail = poll_pending_q && poll_have;
    grant      = (state_q == S_IDLE) && i2c_free && !downstream_full &&
                 (pc_avail || poll_avail);
    pick_poll  = poll_avail && (!pc_avail || last_grant_pc_q);
    grant_poll = grant && pick_poll;
  end

  // Launch pulse and transaction fields, held until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q         <= 1'b0;
      busaddr_q       <= '0;
      mode_q          <= '0;
      reg_q           <= '0;
      data_q          <= '0;
      src_q           <= 1'b0;
      dev_q           <= '0;
      last_grant_pc_q <= 1'b0;
    end else begin
      start_q <= grant;
      if (grant) begin
        last_grant_pc_q <= !pick_poll;
        if (pick_poll) begin
          busaddr_q <= BASE_ADDR + 7'(poll_sel);
          mode_q    <= POLL_MODE;
          reg_q     <= POLL_REG;
          data_q    <= '0;
          src_q     <= 1'b0;
          dev_q     <= poll_sel;
        end else begin
          busaddr_q <= BASE_ADDR + 7'(head_dev);
          mode_q    <= head_mode;
          reg_q     <= head_reg;
          data_q    <= head_data;
          src_q     <= 1'b1;
          dev_q     <= head_dev;
        end
      end
    end
  end

  assign i2c_start    = start_q;
  assign i2c_busaddr  = busaddr_q;
  assign i2c_mode     = mode_q;
  assign i2c_reg      = reg_q;
  assign i2c_data     = data_q;
  assign i2c_src      = src_q;
  assign i2c_dev      = dev_q;
  assign poll_overrun = poll_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_sensor_poll_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_sensor_poll_arbiter
// Purpose  : Randomized self-checking bench with a transaction-level reference
//            model of the poll/PC arbiter and a simple I2C controller stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_sensor_poll_arbiter;

  localparam int NS     = 4;
  localparam int FD     = 8;
  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_valid = 1'b0;
  logic        pc_ready;
  logic [1:0]  pc_dev = '0;
  logic [7:0]  pc_mode = '0;
  logic [7:0]  pc_reg = '0;
  logic [15:0] pc_data = '0;
  logic [3:0]  enable_mask = '0;
  logic        i2c_free = 1'b1;
  logic        downstream_full = 1'b0;
  logic        i2c_start;
  logic [6:0]  i2c_busaddr;
  logic [7:0]  i2c_mode;
  logic [7:0]  i2c_reg;
  logic [15:0] i2c_data;
  logic        i2c_src;
  logic [1:0]  i2c_dev;
  logic [3:0]  fifo_count;
  logic        fifo_full;
  logic        poll_overrun;

  int n_cmp = 0;
  int n_err = 0;

  multi_sensor_poll_arbiter #(
    .NUM_SENSORS(NS), .FIFO_DEPTH(FD), .SYS_FREQ(10000), .POLL_MS(1),
    .DATA_W(16), .BASE_ADDR(7'h48), .POLL_MODE(8'h02), .POLL_REG(8'h00)
  ) dut (
    .clk(clk), .reset(reset),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_dev(pc_dev),
    .pc_mode(pc_mode), .pc_reg(pc_reg), .pc_data(pc_data),
    .enable_mask(enable_mask), .i2c_free(i2c_free),
    .downstream_full(downstream_full), .i2c_start(i2c_start),
    .i2c_busaddr(i2c_busaddr), .i2c_mode(i2c_mode), .i2c_reg(i2c_reg),
    .i2c_data(i2c_data), .i2c_src(i2c_src), .i2c_dev(i2c_dev),
    .fifo_count(fifo_count), .fifo_full(fifo_full),
    .poll_overrun(poll_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- I2C controller stand-in ----------------
  logic hold_busy = 1'b0;
  int   busy_len  = 3;
  int   r_state   = 0;
  int   r_cnt     = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        r_state = 0;
      end else begin
        case (r_state)
          0: if (i2c_start) r_state = 1;
          1: begin r_state = 2; r_cnt = busy_len; end
          default: begin r_cnt--; if (r_cnt <= 0) r_state = 0; end
        endcase
      end
      i2c_free = !(hold_busy || r_state == 2);
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  dev;
    logic [7:0]  mode;
    logic [7:0]  rg;
    logic [15:0] data;
  } ent_t;

  ent_t mq[$];
  ent_t ent;
  int   m_timer, m_next, m_phase, m_sel;
  bit   m_pend, m_lastpc, m_pend_pre, m_pcrdy, m_pollrdy, m_grant, m_tpoll;
  bit   m_push, m_wrap, m_more, m_found;
  int   m_low;
  logic        e_start = 1'b0, e_ovr = 1'b0, e_src = 1'b0;
  logic [6:0]  e_addr = '0;
  logic [7:0]  e_mode = '0, e_reg = '0;
  logic [15:0] e_data = '0;
  logic [1:0]  e_dev = '0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_timer = 0; m_next = 0; m_phase = 0; m_pend = 0; m_lastpc = 0;
      e_start = 0; e_ovr = 0; e_addr = 0; e_mode = 0; e_reg = 0;
      e_data = 0; e_src = 0; e_dev = 0;
    end else begin
      m_pend_pre = m_pend;
      m_pcrdy    = (mq.size() != 0);
      m_pollrdy  = 0;
      m_sel      = 0;
      if (m_pend) begin
        for (int i = m_next; i < NS; i++) begin
          if (!m_pollrdy && enable_mask[i]) begin
            m_pollrdy = 1;
            m_sel     = i;
          end
        end
      end
      m_grant = (m_phase == 0) && i2c_free && !downstream_full && (m_pcrdy || m_pollrdy);
      m_tpoll = m_pollrdy && (!m_pcrdy || m_lastpc);
      m_push  = pc_valid && (mq.size() < FD);
      e_start = m_grant;

      case (m_phase)
        0: if (m_grant)   m_phase = 1;
        1: if (!i2c_free) m_phase = 2;
        default: if (i2c_free) m_phase = 0;
      endcase

      if (m_grant) begin
        m_lastpc = !m_tpoll;
        if (m_tpoll) begin
          e_addr = 7'(72 + m_sel); e_mode = 8'h02; e_reg = 8'h00;
          e_data = 16'h0; e_src = 1'b0; e_dev = 2'(m_sel);
        end else begin
          ent = mq.pop_front();
          e_addr = 7'(72 + int'(ent.dev)); e_mode = ent.mode; e_reg = ent.rg;
          e_data = ent.data; e_src = 1'b1; e_dev = ent.dev;
        end
      end
      if (m_push) begin
        ent.dev = pc_dev; ent.mode = pc_mode; ent.rg = pc_reg; ent.data = pc_data;
        mq.push_back(ent);
      end

      m_wrap  = (m_timer == PERIOD - 1);
      m_timer = m_wrap ? 0 : m_timer + 1;
      e_ovr   = m_wrap && m_pend_pre;
      if (m_wrap && !m_pend_pre) begin
        if (enable_mask != 0) begin
          m_low = NS;
          for (int i = NS - 1; i >= 0; i--) if (enable_mask[i]) m_low = i;
          m_pend = 1;
          m_next = m_low;
        end
      end else if (m_grant && m_tpoll) begin
        m_more = 0;
        for (int j = m_sel + 1; j < NS; j++) if (enable_mask[j]) m_more = 1;
        if (m_more) m_next = m_sel + 1;
        else        m_pend = 0;
      end else if (m_pend_pre && !m_pollrdy) begin
        m_pend = 0;
      end
    end
  end

  // ---------------- cycle monitor ----------------
  logic [7:0] slog[$];
  int n_starts = 0;
  int n_ovr    = 0;

  always @(posedge clk) begin
    #1;
    chk("start", i2c_start, e_start);
    chk("fields", {i2c_busaddr, i2c_mode, i2c_reg, i2c_data, i2c_src, i2c_dev},
                  {e_addr, e_mode, e_reg, e_data, e_src, e_dev});
    chk("count", fifo_count, mq.size());
    chk("full", fifo_full, mq.size() == FD);
    chk("ready", pc_ready, (mq.size() != FD) && !reset);
    chk("overrun", poll_overrun, e_ovr);
    if (i2c_start) begin
      slog.push_back({i2c_src, i2c_busaddr});
      n_starts++;
    end
    if (poll_overrun) n_ovr++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_pc();
    pc_dev  = 2'($urandom_range(0, 3));
    pc_mode = 8'($urandom_range(0, 255));
    pc_reg  = 8'($urandom_range(0, 255));
    pc_data = 16'($urandom_range(0, 65535));
  endtask

  initial begin
    int pc_cnt;
    int base;
    bit found;

    // reset values
    tick(3);
    chk("rst_start", i2c_start, 1'b0);
    chk("rst_count", fifo_count, 4'd0);
    chk("rst_ready", pc_ready, 1'b0);
    chk("rst_addr", i2c_busaddr, 7'd0);
    reset = 1'b0;
    tick(1);
    chk("ready_after_rst", pc_ready, 1'b1);

    // poll rounds only, sensors 0,1,3
    enable_mask = 4'b1011;
    slog.delete();
    tick(60);
    chk("poll_n", slog.size() >= 4, 1'b1);
    if (slog.size() >= 4) begin
      chk("poll0", slog[0], 8'h48);
      chk("poll1", slog[1], 8'h49);
      chk("poll2", slog[2], 8'h4B);
      chk("poll3", slog[3], 8'h48);
    end

    // single PC instruction latency into an idle system
    enable_mask = 4'b0000;
    tick(12);
    pc_valid = 1'b1; pc_dev = 2'd2; pc_mode = 8'h03; pc_reg = 8'h03; pc_data = 16'h1234;
    tick(1);
    pc_valid = 1'b0;
    chk("lat_t1", i2c_start, 1'b0);
    tick(1);
    chk("lat_t2", i2c_start, 1'b1);
    chk("lat_addr", i2c_busaddr, 7'h4A);
    chk("lat_src", i2c_src, 1'b1);
    chk("lat_data", i2c_data, 16'h1234);

    // fill the FIFO while the controller is held busy
    tick(10);
    hold_busy = 1'b1;
    tick(2);
    for (int k = 0; k < 10; k++) begin
      pc_valid = 1'b1;
      rand_pc();
      tick(1);
    end
    pc_valid = 1'b0;
    chk("fill_full", fifo_full, 1'b1);
    chk("fill_ready", pc_ready, 1'b0);
    chk("fill_count", fifo_count, 4'd8);
    slog.delete();
    hold_busy = 1'b0;
    tick(60);
    pc_cnt = 0;
    foreach (slog[i]) if (slog[i][7]) pc_cnt++;
    chk("drain_n", pc_cnt, 8);

    // contention between PC traffic and polling
    busy_len = 1;
    enable_mask = 4'b1111;
    for (int k = 0; k < 60; k++) begin
      pc_valid = 1'b1;
      rand_pc();
      tick(1);
    end
    pc_valid = 1'b0;
    tick(60);

    // slow controller forces overrun
    busy_len = 25;
    enable_mask = 4'b0001;
    n_ovr = 0;
    tick(80);
    chk("overrun_seen", n_ovr > 0, 1'b1);
    busy_len = 3;
    tick(40);

    // downstream back-pressure blocks grants
    downstream_full = 1'b1;
    enable_mask = 4'b1111;
    tick(2);
    base = n_starts;
    for (int k = 0; k < 3; k++) begin
      pc_valid = 1'b1;
      rand_pc();
      tick(1);
    end
    pc_valid = 1'b0;
    tick(30);
    chk("dfull_block", n_starts - base, 0);
    downstream_full = 1'b0;

    // reset while a transaction is in WAIT_DONE
    found = 0;
    for (int k = 0; k < 80 && !found; k++) begin
      tick(1);
      if (i2c_start) found = 1;
    end
    chk("wait_start", found, 1'b1);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_start", i2c_start, 1'b0);
    chk("mid_rst_addr", i2c_busaddr, 7'd0);
    chk("mid_rst_src", i2c_src, 1'b0);
    chk("mid_rst_count", fifo_count, 4'd0);
    tick(30);

    // randomized mix
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0) enable_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) downstream_full = !downstream_full;
      if ($urandom_range(0, 39) == 0) busy_len = $urandom_range(1, 12);
      reset    = ($urandom_range(0, 399) == 0);
      pc_valid = ($urandom_range(0, 3) == 0);
      rand_pc();
      tick(1);
    end
    reset = 1'b0;
    pc_valid = 1'b0;
    downstream_full = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
